memi_bank_ctrl: RTL and testbench

//  Ping-pong loader/scheduler for the two-bank instruction memory MEMI feeding SEQUENCER.

---
 rtl/memi_bank_ctrl.sv | 130 +++++++++++++
 tb/tb_memi_bank_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/memi_bank_ctrl.sv
// memi_bank_ctrl: ping-pong loader/scheduler for the two-bank MEMI instruction memory
module memi_bank_ctrl #(
  parameter int AW    = 14,
  parameter int DW    = 256,
  parameter int DEPTH = 16384
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          soft_clr_i,
  input  logic          hvalid_i,
  output logic          hready_o,
  input  logic [DW-1:0] hdata_i,
  input  logic          hlast_i,
  output logic [AW-1:0] waddri_o,
  output logic          banki_o,
  output logic          wcebi_o,
  output logic [DW-1:0] di_o,
  output logic          seq_purge_o,
  output logic          seq_start_o,
  input  logic          seq_done_i,
  output logic          rbank_o,
  output logic [AW:0]   rlen_o,
  output logic          busy_o,
  output logic          ovf_err_o
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  typedef enum logic [1:0] {R_IDLE, R_PURGE, R_START, R_RUN} rstate_e;
  rstate_e       rstate_q;
  logic          wb_q, rb_q, ovf_q, wceb_q, bank_q, purge_q, start_q;
  logic [1:0]    full_q, full_d;
  logic [AW-1:0] waddr_q, waddr_out_q;
  logic [DW-1:0] di_q;
  logic [AW:0]   len_q [2];
  logic          beat, last, rel;
  assign hready_o    = rst_n & ~full_q[wb_q] & ~soft_clr_i;
  assign beat        = hvalid_i & hready_o;
  assign last        = hlast_i | (waddr_q == LAST_ADDR);
  assign rel         = (rstate_q == R_RUN) & seq_done_i;
  assign waddri_o    = waddr_out_q;
  assign banki_o     = bank_q;
  assign wcebi_o     = wceb_q;
  assign di_o        = di_q;
  assign seq_purge_o = purge_q;
  assign seq_start_o = start_q;
  assign rbank_o     = rb_q;
  assign rlen_o      = len_q[rb_q];
  assign busy_o      = rstate_q != R_IDLE;
  assign ovf_err_o   = ovf_q;
  // Set on last beat into the write bank, cleared on completion of the read bank; the two never collide.
  always_comb begin
    full_d = full_q;
    if (beat && last) full_d[wb_q] = 1'b1;
    if (rel) full_d[rb_q] = 1'b0;
  end
  // Write path: register the MEMI write strobe/address/data and advance the fill pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q        <= 1'b0;
      full_q      <= 2'b00;
      waddr_q     <= '0;
      waddr_out_q <= '0;
      bank_q      <= 1'b0;
      wceb_q      <= 1'b1;
      di_q        <= '0;
      ovf_q       <= 1'b0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
    end else if (soft_clr_i) begin
      wb_q        <= 1'b0;
      full_q      <= 2'b00;
      waddr_q     <= '0;
      waddr_out_q <= '0;
      bank_q      <= 1'b0;
      wceb_q      <= 1'b1;
      di_q        <= '0;
      ovf_q       <= 1'b0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
    end else begin
      full_q <= full_d;
      wceb_q <= ~beat;
      if (beat) begin
        bank_q      <= wb_q;
        waddr_out_q <= waddr_q;
        di_q        <= hdata_i;
        if (last) begin
          len_q[wb_q] <= (AW+1)'(waddr_q) + (AW+1)'(1);
          waddr_q     <= '0;
          wb_q        <= ~wb_q;
          if (!hlast_i) ovf_q <= 1'b1;
        end else begin
          waddr_q <= waddr_q + AW'(1);
        end
      end
    end
  end
  // Read FSM: purge, start, then wait for the sequencer to finish the bank before moving on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      rb_q     <= 1'b0;
      purge_q  <= 1'b0;
      start_q  <= 1'b0;
    end else if (soft_clr_i) begin
      rstate_q <= R_IDLE;
      rb_q     <= 1'b0;
      purge_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      purge_q <= 1'b0;
      start_q <= 1'b0;
      case (rstate_q)
        R_IDLE: if (full_q[rb_q]) begin
          rstate_q <= R_PURGE;
          purge_q  <= 1'b1;
        end
        R_PURGE: begin
          rstate_q <= R_START;
          start_q  <= 1'b1;
        end
        R_START: rstate_q <= R_RUN;
        R_RUN: if (seq_done_i) begin
          rstate_q <= R_IDLE;
          rb_q     <= ~rb_q;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memi_bank_ctrl.sv
// tb_memi_bank_ctrl: directed checks of load, ping-pong hand-off, overflow and reset
module tb_memi_bank_ctrl;
  localparam int AW = 3, DW = 32, DEPTH = 8;
  logic          clk = 1'b0, rst_n, soft_clr, hvalid, hlast, seq_done;
  logic [DW-1:0] hdata;
  logic          hready, banki, wcebi, purge, start, rbank, busy, ovf;
  logic [AW-1:0] waddri;
  logic [DW-1:0] di;
  logic [AW:0]   rlen;
  int checks = 0, errors = 0;
  memi_bank_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr_i(soft_clr), .hvalid_i(hvalid), .hready_o(hready),
    .hdata_i(hdata), .hlast_i(hlast), .waddri_o(waddri), .banki_o(banki), .wcebi_o(wcebi),
    .di_o(di), .seq_purge_o(purge), .seq_start_o(start), .seq_done_i(seq_done),
    .rbank_o(rbank), .rlen_o(rlen), .busy_o(busy), .ovf_err_o(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [DW-1:0] d, input logic l);
    hvalid = 1'b1;
    hdata  = d;
    hlast  = l;
    tick();
    hvalid = 1'b0;
    hlast  = 1'b0;
  endtask
  task automatic sclr();
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; soft_clr = 1'b0; hvalid = 1'b0; hlast = 1'b0; seq_done = 1'b0; hdata = '0;
    tick(); tick();
    chk("rst_hready", hready, 0); chk("rst_wceb", wcebi, 1); chk("rst_busy", busy, 0);
    chk("rst_rlen", rlen, 0); chk("rst_purge", purge, 0); chk("rst_start", start, 0);
    chk("rst_ovf", ovf, 0); chk("rst_waddr", waddri, 0); chk("rst_di", di, 0);
    rst_n = 1'b1;
    #1 chk("post_rst_hready", hready, 1);
    // T1: three-word program
    beat(32'hA0, 0);
    chk("t1_wceb0", wcebi, 0); chk("t1_addr0", waddri, 0); chk("t1_bank0", banki, 0); chk("t1_di0", di, 32'hA0);
    beat(32'hA1, 0);
    chk("t1_addr1", waddri, 1); chk("t1_wceb1", wcebi, 0);
    beat(32'hA2, 1);
    chk("t1_addr2", waddri, 2); chk("t1_wceb2", wcebi, 0); chk("t1_nopurge_n1", purge, 0);
    tick();
    chk("t1_purge", purge, 1); chk("t1_start_early", start, 0); chk("t1_rbank", rbank, 0);
    chk("t1_rlen", rlen, 3); chk("t1_busy", busy, 1); chk("t1_wceb_idle", wcebi, 1);
    tick();
    chk("t1_purge_off", purge, 0); chk("t1_start", start, 1);
    tick();
    chk("t1_start_off", start, 0); chk("t1_run_busy", busy, 1); chk("t1_hready", hready, 1);
    seq_done = 1'b1; tick(); seq_done = 1'b0;
    chk("t1_done_idle", busy, 0); chk("t1_rb_toggle", rbank, 1);
    soft_clr = 1'b1;
    #1 chk("sclr_hready", hready, 0);
    tick(); soft_clr = 1'b0;
    chk("sclr_rbank", rbank, 0); chk("sclr_busy", busy, 0); chk("sclr_wceb", wcebi, 1);
    // T2: back-to-back banks, host stalls until the first bank is released
    beat(32'hB0, 0); beat(32'hB1, 0); beat(32'hB2, 0); beat(32'hB3, 1);
    beat(32'hC0, 0); beat(32'hC1, 1);
    chk("t2_start", start, 1); chk("t2_hready_full", hready, 0);
    chk("t2_bank1", banki, 1); chk("t2_addr1", waddri, 1);
    tick();
    chk("t2_busy", busy, 1); chk("t2_rbank0", rbank, 0); chk("t2_rlen4", rlen, 4); chk("t2_start_off", start, 0);
    hvalid = 1'b1; hdata = 32'hDEAD; seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    chk("t2_hready_rise", hready, 1); chk("t2_no_stall_write", wcebi, 1);
    chk("t2_rbank1", rbank, 1); chk("t2_rlen2", rlen, 2); chk("t2_idle", busy, 0);
    hvalid = 1'b0;
    tick(); chk("t2_purge", purge, 1);
    tick(); chk("t2_start2", start, 1);
    tick(); seq_done = 1'b1; tick(); seq_done = 1'b0;
    chk("t2_end_idle", busy, 0); chk("t2_end_rbank", rbank, 0);
    sclr();
    // T3: overflow at DEPTH without HLAST
    for (int i = 0; i < 8; i++) beat(32'hE0 + i, 0);
    chk("t3_addr7", waddri, 7); chk("t3_wceb", wcebi, 0); chk("t3_di", di, 32'hE7);
    chk("t3_ovf", ovf, 1); chk("t3_bank0", banki, 0); chk("t3_hready", hready, 1);
    beat(32'hF0, 0);
    chk("t3_next_bank", banki, 1); chk("t3_next_addr", waddri, 0); chk("t3_next_wceb", wcebi, 0);
    chk("t3_purge", purge, 1); chk("t3_rlen8", rlen, 8); chk("t3_rbank", rbank, 0); chk("t3_ovf_sticky", ovf, 1);
    sclr();
    chk("sclr_ovf", ovf, 0);
    // T4: last beat into bank1 coincides with done on bank0
    beat(32'h10, 0); beat(32'h11, 1);
    tick(); tick(); tick();
    chk("t4_run", busy, 1);
    seq_done = 1'b1; beat(32'h20, 1); seq_done = 1'b0;
    chk("t4_rbank1", rbank, 1); chk("t4_idle", busy, 0); chk("t4_rlen1", rlen, 1);
    chk("t4_hready", hready, 1); chk("t4_bank1", banki, 1); chk("t4_addr0", waddri, 0);
    tick(); chk("t4_purge", purge, 1); chk("t4_purge_rbank", rbank, 1);
    tick(); chk("t4_start", start, 1);
    tick(); chk("t4_run1", busy, 1);
    // T5: asynchronous reset mid-run and mid-load
    beat(32'h30, 0);
    chk("t5_wceb", wcebi, 0); chk("t5_bank", banki, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_wceb_rst", wcebi, 1); chk("t5_addr_rst", waddri, 0); chk("t5_bank_rst", banki, 0);
    chk("t5_di_rst", di, 0); chk("t5_busy_rst", busy, 0); chk("t5_rlen_rst", rlen, 0);
    chk("t5_hready_rst", hready, 0); chk("t5_purge_rst", purge, 0); chk("t5_start_rst", start, 0);
    chk("t5_rbank_rst", rbank, 0);
    tick(); tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_quiet_purge", purge, 0); chk("t5_quiet_start", start, 0);
    end
    chk("t5_quiet_busy", busy, 0);
    beat(32'h40, 1);
    tick(); chk("t5_fresh_purge", purge, 1); chk("t5_fresh_rlen", rlen, 1);
    tick(); chk("t5_fresh_start", start, 1);
    tick(); seq_done = 1'b1; tick(); seq_done = 1'b0;
    sclr();
    // T6: done outside R_RUN is ignored
    seq_done = 1'b1;
    tick(); chk("t6_idle_done", busy, 0);
    beat(32'h50, 1);
    chk("t6_n1_idle", busy, 0);
    tick(); chk("t6_purge", purge, 1); chk("t6_purge_busy", busy, 1);
    tick(); chk("t6_start", start, 1); chk("t6_rbank", rbank, 0);
    seq_done = 1'b0;
    tick(); chk("t6_run", busy, 1); chk("t6_start_once", start, 0); chk("t6_rbank_run", rbank, 0);
    tick(); chk("t6_run_hold", busy, 1); chk("t6_no_purge", purge, 0);
    seq_done = 1'b1; tick(); seq_done = 1'b0;
    chk("t6_done", busy, 0); chk("t6_rbank1", rbank, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
